multicycle_control_fsm: RTL and testbench

//  Main control sequencer for the multicycle RISC-V core variant. Steps shared datapath (one ALU, one memory port)

---
 rtl/multicycle_control_fsm_pkg.sv | 66 ++++++
 rtl/multicycle_control_fsm_alu_decoder.sv | 34 +++
 rtl/multicycle_control_fsm.sv | 156 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RISC-V control sequencer: state codes,
// supported opcodes, datapath mux selects and the per-state control word.
package multicycle_control_fsm_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_JAL      = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_supported_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU decoder: turns ALUOp plus instruction fields into the 3-bit ALU control.
module alu_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [6:0] op,
  output logic [2:0] alu_control
);

  // Only R-type distinguishes sub from add; for I-type funct7 is immediate bits.
  logic r_sub;
  assign r_sub = (op == OP_R) && (funct7 == 7'b0100000);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = r_sub ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer: steps the shared ALU/memory datapath through
// fetch, decode, execute and writeback for lw, sw, R/I-type, beq and jal.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal_op
);

  logic [3:0] state, state_nxt;
  ctrl_t      ctl;

  always_ff @(posedge clk) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXEC_R;
          OP_I:         state_nxt = S_EXEC_I;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC_R:   state_nxt = S_ALUWB;
      S_EXEC_I:   state_nxt = S_ALUWB;
      S_JAL:      state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.alu_src_a  = SRCA_PC;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.alu_op     = ALUOP_ADD;
        ctl.result_src = RES_ALURESULT;
        ctl.ir_write   = mem_ready;
        ctl.pc_update  = mem_ready;
      end
      S_DECODE: begin
        // PC was already advanced in fetch, so an unsupported opcode retires as a NOP here.
        ctl.alu_src_a  = SRCA_OLDPC;
        ctl.alu_src_b  = SRCB_IMM;
        ctl.alu_op     = ALUOP_ADD;
        ctl.illegal_op = !is_supported_op(op);
        ctl.instr_done = !is_supported_op(op);
      end
      S_MEMADR: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctl.result_src = RES_ALUOUT;
        ctl.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        ctl.result_src = RES_DATA;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.result_src = RES_ALUOUT;
        ctl.adr_src    = 1'b1;
        ctl.mem_write  = 1'b1;
        ctl.instr_done = mem_ready;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_RS2;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      S_JAL: begin
        ctl.alu_src_a  = SRCA_OLDPC;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.alu_op     = ALUOP_ADD;
        ctl.result_src = RES_ALUOUT;
        ctl.pc_update  = 1'b1;
      end
      S_ALUWB: begin
        ctl.result_src = RES_ALUOUT;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctl.alu_src_a  = SRCA_RS1;
        ctl.alu_src_b  = SRCB_RS2;
        ctl.alu_op     = ALUOP_SUB;
        ctl.result_src = RES_ALUOUT;
        ctl.branch     = 1'b1;
        ctl.instr_done = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  // Reset silences every strobe immediately so an aborted instruction writes nothing.
  assign pc_write   = !reset & (ctl.pc_update | (ctl.branch & zero));
  assign adr_src    = !reset & ctl.adr_src;
  assign mem_write  = !reset & ctl.mem_write;
  assign ir_write   = !reset & ctl.ir_write;
  assign result_src = reset ? 2'b00 : ctl.result_src;
  assign alu_src_a  = reset ? 2'b00 : ctl.alu_src_a;
  assign alu_src_b  = reset ? 2'b00 : ctl.alu_src_b;
  assign reg_write  = !reset & ctl.reg_write;
  assign instr_done = !reset & ctl.instr_done;
  assign illegal_op = !reset & ctl.illegal_op;

  alu_decoder u_alu_dec (
    .alu_op      (ctl.alu_op),
    .funct3      (funct3),
    .funct7      (funct7),
    .op          (op),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: an instruction-level step model checked every
// cycle, plus directed instructions with hand-computed latencies and pinned outputs.
module tb_multicycle_control_fsm;

  logic       clk, reset;
  logic [6:0] op, funct7;
  logic [2:0] funct3;
  logic       zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .alu_control(alu_control), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instruction-level model: each instruction class is a list of steps;
  // fetch/memread/memwrite steps hold until mem_ready.
  typedef enum int {C_NONE, C_LW, C_SW, C_R, C_I, C_J, C_B, C_ILL} cls_e;
  typedef enum int {K_F, K_D, K_A, K_RD, K_MWB, K_WR, K_XR, K_XI, K_J, K_AWB, K_B} kind_e;

  typedef struct packed {
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, sa, sb;
    logic       rw;
    logic [2:0] ac;
    logic       done, ill;
  } exp_t;

  cls_e mcls = C_NONE;
  int   mstep = 0;

  function automatic cls_e classify(input logic [6:0] o);
    case (o)
      7'b0000011: return C_LW;
      7'b0100011: return C_SW;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1101111: return C_J;
      7'b1100011: return C_B;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic int len_of(input cls_e c);
    case (c)
      C_LW:    return 5;
      C_SW, C_R, C_I, C_J: return 4;
      C_B:     return 3;
      default: return 2;
    endcase
  endfunction

  function automatic kind_e kind_of(input cls_e c, input int s);
    if (s == 0) return K_F;
    if (s == 1) return K_D;
    case (c)
      C_LW: return (s == 2) ? K_A : (s == 3) ? K_RD : K_MWB;
      C_SW: return (s == 2) ? K_A : K_WR;
      C_R:  return (s == 2) ? K_XR : K_AWB;
      C_I:  return (s == 2) ? K_XI : K_AWB;
      C_J:  return (s == 2) ? K_J : K_AWB;
      C_B:  return K_B;
      default: return K_F;
    endcase
  endfunction

  function automatic logic [2:0] alu_ref(input int aop, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [6:0] o);
    if (aop == 0) return 3'b000;
    if (aop == 1) return 3'b001;
    case (f3)
      3'b000:  return (o == 7'b0110011 && f7 == 7'b0100000) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   aop;
    e = '0;
    aop = 0;
    if (!reset) begin
      case (kind_of(mcls, mstep))
        K_F:   begin e.sb = 2; e.rs = 2; e.irw = mem_ready; e.pcw = mem_ready; end
        K_D:   begin e.sa = 1; e.sb = 1; e.ill = (classify(op) == C_ILL); e.done = e.ill; end
        K_A:   begin e.sa = 2; e.sb = 1; end
        K_RD:  begin e.adr = 1; end
        K_MWB: begin e.rs = 1; e.rw = 1; e.done = 1; end
        K_WR:  begin e.adr = 1; e.mw = 1; e.done = mem_ready; end
        K_XR:  begin e.sa = 2; e.sb = 0; aop = 2; end
        K_XI:  begin e.sa = 2; e.sb = 1; aop = 2; end
        K_J:   begin e.sa = 1; e.sb = 2; e.pcw = 1; end
        K_AWB: begin e.rw = 1; e.done = 1; end
        K_B:   begin e.sa = 2; aop = 1; e.pcw = zero; e.done = 1; end
        default: e = '0;
      endcase
    end
    e.ac = alu_ref(aop, funct3, funct7, op);
    return e;
  endfunction

  always @(posedge clk) begin
    kind_e k;
    k = kind_of(mcls, mstep);
    if (reset) mstep = 0;
    else begin
      if (k == K_D) mcls = classify(op);
      if (!((k == K_F || k == K_RD || k == K_WR) && !mem_ready))
        mstep = (mstep + 1 == len_of(mcls)) ? 0 : mstep + 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = model_out();
    chk("pc_write",   pc_write,   e.pcw);
    chk("adr_src",    adr_src,    e.adr);
    chk("mem_write",  mem_write,  e.mw);
    chk("ir_write",   ir_write,   e.irw);
    chk("result_src", result_src, e.rs);
    chk("alu_src_a",  alu_src_a,  e.sa);
    chk("alu_src_b",  alu_src_b,  e.sb);
    chk("reg_write",  reg_write,  e.rw);
    chk("instr_done", instr_done, e.done);
    chk("illegal_op", illegal_op, e.ill);
    if (!reset) chk("alu_control", alu_control, e.ac);
  end

  // Per-cycle log of the last directed instruction, for literal pins.
  logic       lg_pcw [64];
  logic       lg_irw [64];
  logic       lg_rw  [64];
  logic [1:0] lg_rs  [64];
  logic [1:0] lg_sb  [64];
  logic [2:0] lg_ac  [64];
  int         n_rw, n_mw, n_ill;

  task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input int sf, input int sm,
                           input int exp_cyc, input int exp_rw, input int exp_mw);
    int    cyc, sfl, sml;
    logic  done;
    kind_e k;
    op = o; funct3 = f3; funct7 = f7; zero = z;
    sfl = sf; sml = sm; cyc = 0; done = 0;
    n_rw = 0; n_mw = 0; n_ill = 0;
    while (!done && cyc < 50) begin
      k = kind_of(mcls, mstep);
      if (k == K_F && sfl > 0) begin mem_ready = 0; sfl--; end
      else if ((k == K_RD || k == K_WR) && sml > 0) begin mem_ready = 0; sml--; end
      else mem_ready = 1;
      @(negedge clk);
      lg_pcw[cyc] = pc_write; lg_irw[cyc] = ir_write; lg_rw[cyc] = reg_write;
      lg_rs[cyc] = result_src; lg_sb[cyc] = alu_src_b; lg_ac[cyc] = alu_control;
      n_rw += int'(reg_write); n_mw += int'(mem_write); n_ill += int'(illegal_op);
      done = instr_done;
      cyc++;
      @(posedge clk); #1;
    end
    chk({nm, " cycles"}, cyc, exp_cyc);
    chk({nm, " reg_write count"}, n_rw, exp_rw);
    chk({nm, " mem_write count"}, n_mw, exp_mw);
  endtask

  initial begin
    int rw_seen;
    reset = 1; op = 0; funct3 = 0; funct7 = 0; zero = 0; mem_ready = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    run_instr("lw", 7'b0000011, 3'b010, 7'd0, 0, 0, 0, 5, 1, 0);
    chk("fetch ir_write", lg_irw[0], 1);
    chk("fetch pc_write", lg_pcw[0], 1);
    chk("fetch alu_src_b", lg_sb[0], 2);
    chk("lw reg_write cyc5", lg_rw[4], 1);
    chk("lw reg_write cyc4", lg_rw[3], 0);
    chk("lw result_src cyc5", lg_rs[4], 1);

    run_instr("sub", 7'b0110011, 3'b000, 7'b0100000, 0, 0, 0, 4, 1, 0);
    chk("sub alu_control", lg_ac[2], 1);
    chk("sub reg_write wb", lg_rw[3], 1);

    run_instr("beq taken", 7'b1100011, 3'b000, 7'd0, 1, 0, 0, 3, 0, 0);
    chk("beq taken pc_write", lg_pcw[2], 1);
    chk("beq alu_control", lg_ac[2], 1);
    run_instr("beq not taken", 7'b1100011, 3'b000, 7'd0, 0, 0, 0, 3, 0, 0);
    chk("beq not taken pc_write", lg_pcw[2], 0);

    run_instr("sw stall", 7'b0100011, 3'b010, 7'd0, 0, 0, 3, 7, 0, 4);
    run_instr("sw", 7'b0100011, 3'b010, 7'd0, 0, 0, 0, 4, 0, 1);

    run_instr("illegal", 7'b1111111, 3'b000, 7'd0, 0, 0, 0, 2, 0, 0);
    chk("illegal_op pulses", n_ill, 1);

    run_instr("addi", 7'b0010011, 3'b000, 7'b0100000, 0, 0, 0, 4, 1, 0);
    chk("addi alu_control", lg_ac[2], 0);
    run_instr("ori", 7'b0010011, 3'b110, 7'd0, 0, 0, 0, 4, 1, 0);
    chk("ori alu_control", lg_ac[2], 3);
    run_instr("and", 7'b0110011, 3'b111, 7'd0, 0, 2, 0, 6, 1, 0);
    chk("and alu_control", lg_ac[4], 2);
    run_instr("slt", 7'b0110011, 3'b010, 7'd0, 0, 0, 0, 4, 1, 0);
    chk("slt alu_control", lg_ac[2], 5);
    run_instr("jal", 7'b1101111, 3'b000, 7'd0, 0, 0, 0, 4, 1, 0);
    chk("jal pc_write", lg_pcw[2], 1);
    run_instr("lw stall", 7'b0000011, 3'b010, 7'd0, 0, 1, 2, 8, 1, 0);

    // Reset while lw waits in memread: no write-back, restart at fetch.
    op = 7'b0000011; funct3 = 3'b010; funct7 = 0; mem_ready = 1; rw_seen = 0;
    repeat (3) begin @(negedge clk); rw_seen += int'(reg_write); @(posedge clk); #1; end
    mem_ready = 0;
    @(negedge clk);
    chk("memread adr_src", adr_src, 1);
    rw_seen += int'(reg_write);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    rw_seen += int'(reg_write);
    @(posedge clk); #1;
    reset = 0; mem_ready = 1;
    @(negedge clk);
    chk("post-abort ir_write", ir_write, 1);
    chk("post-abort adr_src", adr_src, 0);
    rw_seen += int'(reg_write);
    chk("abort reg_write count", rw_seen, 0);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
